// File: rtl/sw_debounce_mode_pkg.sv
// Shared definitions for the mode-switch conditioning path: FSM state
// encoding and the debounce interval defaults.
package sw_debounce_mode_pkg;

  // 2-bit state encoding; the values are fixed so the state register can be
  // read back from a debug port without a lookup table.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  // 20 ms at 50 MHz.
  localparam int unsigned STABLE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned CNT_W_DEFAULT         = 20;

  // Short interval for simulation so a debounce completes in a few cycles.
  localparam int unsigned STABLE_CYCLES_SIM     = 4;
  localparam int unsigned CNT_W_SIM             = 3;

endpackage

// File: rtl/sw_debounce_mode_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. Kept generic so the
// reset switch can reuse it.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q may be used by downstream logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sw_debounce_mode.sv
// Debounce for the `mode` slide switch feeding the LED sequencer.
// Synchronises sw_in, waits for STABLE_CYCLES consecutive cycles of a new
// level, then commits it to `mode` with a one-cycle edge pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE_LOW  | mode=0, synchronised input agrees, counter held at 0
// WAIT_HIGH | mode=0, input high, counting towards a rising commit
// IDLE_HIGH | mode=1, synchronised input agrees, counter held at 0
// WAIT_LOW  | mode=1, input low, counting towards a falling commit
module sw_debounce_mode
  import sw_debounce_mode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk50M,
  input  logic reset,
  input  logic sw_in,
  output logic mode,
  output logic mode_rise,
  output logic mode_fall,
  output logic mode_toggle
);

  // The first differing cycle loads 1, so the commit lands on the
  // STABLE_CYCLES-th consecutive differing sample.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk   (clk50M),
    .reset (reset),
    .d     (sw_in),
    .q     (sync2)
  );

  // Debounce FSM, stability counter and registered edge outputs.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      state       <= IDLE_LOW;
      cnt         <= '0;
      mode        <= 1'b0;
      mode_rise   <= 1'b0;
      mode_fall   <= 1'b0;
      mode_toggle <= 1'b0;
    end else begin
      mode_rise <= 1'b0;
      mode_fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync2) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            // Glitch: back to the committed level, discard the count.
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE_HIGH;
            cnt         <= '0;
            mode        <= 1'b1;
            mode_rise   <= 1'b1;
            mode_toggle <= ~mode_toggle;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync2) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (sync2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // Toggle only follows presses, so a release leaves it alone.
            state     <= IDLE_LOW;
            cnt       <= '0;
            mode      <= 1'b0;
            mode_fall <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_debounce_mode.sv
// Directed bench for sw_debounce_mode with the short simulation interval.
module tb_sw_debounce_mode;
  import sw_debounce_mode_pkg::*;

  localparam int SC = STABLE_CYCLES_SIM;

  logic clk50M = 1'b0;
  logic reset  = 1'b1;
  logic sw_in  = 1'b0;
  logic mode, mode_rise, mode_fall, mode_toggle;

  sw_debounce_mode #(
    .STABLE_CYCLES (STABLE_CYCLES_SIM),
    .CNT_W         (CNT_W_SIM)
  ) dut (
    .clk50M      (clk50M),
    .reset       (reset),
    .sw_in       (sw_in),
    .mode        (mode),
    .mode_rise   (mode_rise),
    .mode_fall   (mode_fall),
    .mode_toggle (mode_toggle)
  );

  always #10 clk50M = ~clk50M;

  typedef struct packed {
    logic m;
    logic r;
    logic f;
    logic t;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: run length of synchronised samples differing from mode.
  logic m_s1, m_s2, m_mode, m_rise, m_fall, m_tog;
  int   m_run;

  int   edge_no;
  int   rise_edge;
  int   n_rise;
  int   n_fall;
  int   pulse_kind[$];
  logic pulse_tog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic sw, input logic rst);
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_mode = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_tog = 1'b0; m_run = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_s2 != m_mode) begin
        m_run++;
        if (m_run == SC) begin
          m_mode = ~m_mode;
          if (m_mode) begin
            m_rise = 1'b1;
            m_tog  = ~m_tog;
          end else begin
            m_fall = 1'b1;
          end
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  endtask

  // One clock: drive, predict, wait for the edge, then compare the output.
  task automatic step(input logic sw, input logic rst);
    exp_t e;
    exp_t got;
    sw_in = sw;
    reset = rst;
    model_edge(sw, rst);
    e = {m_mode, m_rise, m_fall, m_tog};
    sb_q.push_back(e);
    @(posedge clk50M);
    #1;
    edge_no++;
    got = {mode, mode_rise, mode_fall, mode_toggle};
    e = sb_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL outputs edge %0d {mode,rise,fall,tog} observed %b expected %b",
             edge_no, got, e);
    end
    checks++;
    assert (!(mode_rise === 1'b1 && mode_fall === 1'b1)) else begin
      errors++;
      $error("FAIL rise_fall_exclusive observed 11 expected not both");
    end
    if (mode_rise === 1'b1) begin
      n_rise++;
      rise_edge = edge_no;
      pulse_kind.push_back(1);
      pulse_tog.push_back(mode_toggle);
    end
    if (mode_fall === 1'b1) begin
      n_fall++;
      pulse_kind.push_back(0);
      pulse_tog.push_back(mode_toggle);
    end
  endtask

  task automatic clear_stats();
    edge_no   = 0;
    rise_edge = -1;
    n_rise    = 0;
    n_fall    = 0;
    pulse_kind.delete();
    pulse_tog.delete();
  endtask

  task automatic hold(input logic sw, input int n);
    for (int i = 0; i < n; i++) step(sw, 1'b0);
  endtask

  initial begin
    clear_stats();

    // Reset, then idle low.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("reset_state", 32'(dut.state), 32'(IDLE_LOW));
    chk("reset_cnt", 32'(dut.cnt), 0);
    clear_stats();
    hold(1'b0, 20);
    chk("idle_rises", n_rise, 0);
    chk("idle_falls", n_fall, 0);
    chk("idle_cnt", 32'(dut.cnt), 0);

    // Clean rising step: mode changes on edge SC+2.
    clear_stats();
    hold(1'b1, 10);
    chk("step_rise_edge", rise_edge, SC + 2);
    chk("step_rise_count", n_rise, 1);
    chk("step_toggle", 32'(mode_toggle), 1);
    chk("step_mode", 32'(mode), 1);

    // Back low, then bounce and settle high.
    hold(1'b0, 10);
    chk("release_mode", 32'(mode), 0);
    clear_stats();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    edge_no = 0;
    hold(1'b1, 10);
    chk("bounce_rise_edge", rise_edge, SC + 2);
    chk("bounce_rise_count", n_rise, 1);
    chk("bounce_toggle", 32'(mode_toggle), 0);

    // Short pulse one cycle below the threshold.
    hold(1'b0, 10);
    clear_stats();
    hold(1'b1, SC - 1);
    hold(1'b0, 10);
    chk("short_rises", n_rise, 0);
    chk("short_falls", n_fall, 0);
    chk("short_mode", 32'(mode), 0);
    chk("short_cnt", 32'(dut.cnt), 0);
    chk("short_state", 32'(dut.state), 32'(IDLE_LOW));

    // Two press/release cycles.
    clear_stats();
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    chk("pp_pulses", pulse_kind.size(), 4);
    if (pulse_kind.size() == 4) begin
      chk("pp_kind0", pulse_kind[0], 1);
      chk("pp_kind1", pulse_kind[1], 0);
      chk("pp_kind2", pulse_kind[2], 1);
      chk("pp_kind3", pulse_kind[3], 0);
      chk("pp_tog0", 32'(pulse_tog[0]), 1);
      chk("pp_tog1", 32'(pulse_tog[1]), 1);
      chk("pp_tog2", 32'(pulse_tog[2]), 0);
      chk("pp_tog3", 32'(pulse_tog[3]), 0);
    end

    // Leave toggle at 1, then reset in the middle of WAIT_HIGH.
    hold(1'b1, 8);
    hold(1'b0, 8);
    chk("pre_reset_toggle", 32'(mode_toggle), 1);
    hold(1'b1, 4);
    chk("midwait_state", 32'(dut.state), 32'(WAIT_HIGH));
    chk("midwait_cnt", 32'(dut.cnt), 2);
    clear_stats();
    step(1'b1, 1'b1);
    chk("midreset_state", 32'(dut.state), 32'(IDLE_LOW));
    chk("midreset_cnt", 32'(dut.cnt), 0);
    chk("midreset_toggle", 32'(mode_toggle), 0);
    chk("midreset_pulses", n_rise + n_fall, 0);
    clear_stats();
    hold(1'b1, 10);
    chk("post_reset_rise_edge", rise_edge, SC + 2);
    chk("post_reset_rise_count", n_rise, 1);
    chk("post_reset_mode", 32'(mode), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
